// File: rtl/cube_pkg.sv
// Shared constants, state encoding and helpers for the cube sticker store.
// Used by the color writer and its switch debouncer.
package cube_pkg;

   localparam int N_STICKERS = 24;
   localparam int N_COLORS   = 6;
   localparam int COLOR_W    = 3;
   localparam int IDX_W      = 5;
   localparam int N_COLS     = 8;
   localparam int N_ROWS     = 6;

   localparam logic [2:0] FACE_TOP    = 3'd0;
   localparam logic [2:0] FACE_LEFT   = 3'd1;
   localparam logic [2:0] FACE_FRONT  = 3'd2;
   localparam logic [2:0] FACE_RIGHT  = 3'd3;
   localparam logic [2:0] FACE_BACK   = 3'd4;
   localparam logic [2:0] FACE_BOTTOM = 3'd5;
   localparam logic [2:0] FACE_NONE   = 3'd7;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PRESS_DB,
      ST_LOCATE,
      ST_WRITE,
      ST_WAIT_REL,
      ST_REL_DB
   } state_e;

   // Map a 2x2 cell block (row pair, column pair) onto the unfolded net.
   function automatic logic [2:0] face_lookup(
      input logic [1:0] rp,
      input logic [1:0] cp
   );
      logic [2:0] f;
      f = FACE_NONE;
      case (rp)
         2'd0: if (cp == 2'd1) f = FACE_TOP;
         2'd1: begin
            case (cp)
               2'd0:    f = FACE_LEFT;
               2'd1:    f = FACE_FRONT;
               2'd2:    f = FACE_RIGHT;
               default: f = FACE_BACK;
            endcase
         end
         2'd2: if (cp == 2'd1) f = FACE_BOTTOM;
         default: f = FACE_NONE;
      endcase
      return f;
   endfunction

   // Next color in the 0..5 cycle; stray 6/7 fold back to 0.
   function automatic logic [COLOR_W-1:0] next_color(
      input logic [COLOR_W-1:0] c
   );
      logic [COLOR_W-1:0] n;
      if (c >= COLOR_W'(N_COLORS - 1)) n = '0;
      else                             n = c + COLOR_W'(1);
      return n;
   endfunction

endpackage

// File: rtl/cube_color_writer_debounce.sv
// Push-button synchronizer and press/release debounce sequencer.
// Emits a locate strobe, a write strobe and a held level per press.
module switch_debounce
   import cube_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 250000
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic sw_i,
   output logic press_o,
   output logic write_o,
   output logic held_o
);

   localparam int CW = (DEBOUNCE_CYCLES > 1) ?
                       $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [1:0]    sync_q;
   logic          sw_s;
   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [CW-1:0] cnt_inc;

   assign sw_s = sync_q[1];

   // Two-flop synchronizer for the raw asynchronous button.
   always_ff @(posedge clk_i) begin
      if (rst_i) sync_q <= '0;
      else       sync_q <= {sync_q[0], sw_i};
   end

   // State and debounce counter registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state logic; the counter saturates at its terminal value.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      cnt_inc = (cnt_q == CNT_LAST) ? cnt_q : cnt_q + CW'(1);
      unique case (state_q)
         ST_IDLE: begin
            if (sw_s) begin
               cnt_d   = '0;
               state_d = ST_PRESS_DB;
            end
         end
         ST_PRESS_DB: begin
            if (!sw_s)                 state_d = ST_IDLE;
            else if (cnt_q == CNT_LAST) state_d = ST_LOCATE;
            else                       cnt_d   = cnt_inc;
         end
         ST_LOCATE: state_d = ST_WRITE;
         ST_WRITE:  state_d = ST_WAIT_REL;
         ST_WAIT_REL: begin
            if (!sw_s) begin
               cnt_d   = '0;
               state_d = ST_REL_DB;
            end
         end
         ST_REL_DB: begin
            if (sw_s)                  state_d = ST_WAIT_REL;
            else if (cnt_q == CNT_LAST) state_d = ST_IDLE;
            else                       cnt_d   = cnt_inc;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign press_o = (state_q == ST_LOCATE);
   assign write_o = (state_q == ST_WRITE);
   assign held_o  = (state_q == ST_LOCATE)   ||
                    (state_q == ST_WRITE)    ||
                    (state_q == ST_WAIT_REL) ||
                    (state_q == ST_REL_DB);

endmodule

// File: rtl/cube_color_writer.sv
// Sticker color store: advances the sticker under the selector on
// each debounced button press and serves a registered read port.
module cube_color_writer
   import cube_pkg::*;
#(
   parameter int CELL            = 60,
   parameter int MARGIN          = 5,
   parameter int DEBOUNCE_CYCLES = 250000
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               color_switch,
   input  logic [9:0]         selector_x,
   input  logic [9:0]         selector_y,
   input  logic [IDX_W-1:0]   rd_index,
   output logic [COLOR_W-1:0] rd_color,
   output logic               write_pulse,
   output logic [IDX_W-1:0]   wr_index,
   output logic               miss,
   output logic               busy
);

   logic locate_s;
   logic write_s;

   logic [2:0]   col_c, row_c;
   logic         col_ok, row_ok;
   logic [9:0]   xoff_c, yoff_c;
   logic         in_x, in_y;
   logic [2:0]   face_c;
   logic         hit_c;
   logic [IDX_W-1:0] idx_c;

   logic             hit_q;
   logic [IDX_W-1:0] idx_q;
   logic [COLOR_W-1:0] stk_q [N_STICKERS];
   logic [COLOR_W-1:0] rd_color_q;
   logic               wr_en;

   switch_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_db (
      .clk_i  (clock),
      .rst_i  (reset),
      .sw_i   (color_switch),
      .press_o(locate_s),
      .write_o(write_s),
      .held_o (busy)
   );

   // Column decode: compare chain against multiples of CELL.
   always_comb begin
      col_c  = '0;
      col_ok = 1'b0;
      xoff_c = '0;
      for (int k = N_COLS - 1; k >= 0; k--) begin
         if ({1'b0, selector_x} < 11'((k + 1) * CELL)) begin
            col_c  = 3'(k);
            xoff_c = selector_x - 10'(k * CELL);
            col_ok = 1'b1;
         end
      end
   end

   // Row decode: compare chain against multiples of CELL.
   always_comb begin
      row_c  = '0;
      row_ok = 1'b0;
      yoff_c = '0;
      for (int k = N_ROWS - 1; k >= 0; k--) begin
         if ({1'b0, selector_y} < 11'((k + 1) * CELL)) begin
            row_c  = 3'(k);
            yoff_c = selector_y - 10'(k * CELL);
            row_ok = 1'b1;
         end
      end
   end

   // Margin test, face lookup and sticker index.
   always_comb begin
      in_x   = (xoff_c >= 10'(MARGIN + 1)) &&
               (xoff_c <= 10'(CELL - MARGIN - 1));
      in_y   = (yoff_c >= 10'(MARGIN + 1)) &&
               (yoff_c <= 10'(CELL - MARGIN - 1));
      face_c = face_lookup(row_c[2:1], col_c[2:1]);
      hit_c  = col_ok && row_ok && in_x && in_y &&
               (face_c != FACE_NONE);
      idx_c  = {face_c, row_c[0], col_c[0]};
   end

   // Latch the hit result while locating; held for the write cycle.
   always_ff @(posedge clock) begin
      if (reset) begin
         hit_q <= 1'b0;
         idx_q <= '0;
      end else if (locate_s) begin
         hit_q <= hit_c;
         idx_q <= idx_c;
      end
   end

   assign wr_en = write_s && hit_q;

   // Sticker registers: each face starts solid in its own color.
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < N_STICKERS; i++) begin
            stk_q[i] <= COLOR_W'(i / 4);
         end
      end else if (wr_en) begin
         stk_q[idx_q] <= next_color(stk_q[idx_q]);
      end
   end

   // Registered read port; same-cycle write shows the old color.
   always_ff @(posedge clock) begin
      if (reset) begin
         rd_color_q <= '0;
      end else if (rd_index < IDX_W'(N_STICKERS)) begin
         rd_color_q <= stk_q[rd_index];
      end else begin
         rd_color_q <= '0;
      end
   end

   assign rd_color    = rd_color_q;
   assign write_pulse = wr_en;
   assign wr_index    = wr_en ? idx_q : '0;
   assign miss        = write_s && !hit_q;

endmodule

// File: tb/tb_cube_color_writer.sv
// Directed bench for cube_color_writer with a short debounce.
// Checks reset colors, hits, misses, wrap, bounce and reset recovery.
module tb_cube_color_writer;

   logic       clock;
   logic       reset;
   logic       color_switch;
   logic [9:0] selector_x;
   logic [9:0] selector_y;
   logic [4:0] rd_index;
   logic [2:0] rd_color;
   logic       write_pulse;
   logic [4:0] wr_index;
   logic       miss;
   logic       busy;

   int n_tests = 0;
   int n_fail  = 0;
   int wp_cnt  = 0;
   int miss_cnt = 0;
   logic [4:0] last_wr = '0;

   int wp0, ms0;
   logic [2:0] c;

   cube_color_writer #(
      .CELL(60),
      .MARGIN(5),
      .DEBOUNCE_CYCLES(4)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .color_switch(color_switch),
      .selector_x  (selector_x),
      .selector_y  (selector_y),
      .rd_index    (rd_index),
      .rd_color    (rd_color),
      .write_pulse (write_pulse),
      .wr_index    (wr_index),
      .miss        (miss),
      .busy        (busy)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Strobe counters sampled mid-cycle.
   always @(negedge clock) begin
      if (write_pulse) begin
         wp_cnt  <= wp_cnt + 1;
         last_wr <= wr_index;
      end
      if (miss) miss_cnt <= miss_cnt + 1;
   end

   task automatic check(input string tag,
                        input int obs,
                        input int exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic rd(input int idx, output logic [2:0] col);
      rd_index = 5'(idx);
      @(negedge clock);
      col = rd_color;
   endtask

   task automatic press(input int x, input int y, input int hold);
      selector_x   = 10'(x);
      selector_y   = 10'(y);
      color_switch = 1'b1;
      repeat (hold) @(negedge clock);
      color_switch = 1'b0;
      repeat (20) @(negedge clock);
   endtask

   task automatic hit_case(input string tag, input int x, input int y,
                           input int idx, input int col);
      wp0 = wp_cnt;
      ms0 = miss_cnt;
      press(x, y, 20);
      check({tag, "_writes"}, wp_cnt - wp0, 1);
      check({tag, "_misses"}, miss_cnt - ms0, 0);
      check({tag, "_wr_index"}, int'(last_wr), idx);
      rd(idx, c);
      check({tag, "_color"}, int'(c), col);
   endtask

   task automatic miss_case(input string tag, input int x, input int y);
      wp0 = wp_cnt;
      ms0 = miss_cnt;
      press(x, y, 20);
      check({tag, "_misses"}, miss_cnt - ms0, 1);
      check({tag, "_writes"}, wp_cnt - wp0, 0);
   endtask

   initial begin
      reset        = 1'b1;
      color_switch = 1'b0;
      selector_x   = '0;
      selector_y   = '0;
      rd_index     = '0;
      repeat (3) @(negedge clock);

      check("rst_write_pulse", int'(write_pulse), 0);
      check("rst_miss", int'(miss), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_wr_index", int'(wr_index), 0);
      check("rst_rd_color", int'(rd_color), 0);
      reset = 1'b0;
      @(negedge clock);

      // Reset colors: each face solid in its own number.
      for (int i = 0; i < 24; i++) begin
         rd(i, c);
         check($sformatf("rst_sticker%0d", i), int'(c), i / 4);
      end
      rd(31, c);
      check("rd_oob_31", int'(c), 0);

      // Single hit on the front face, then the full wrap.
      hit_case("hit_200", 200, 200, 11, 3);
      hit_case("wrap1", 200, 200, 11, 4);
      hit_case("wrap2", 200, 200, 11, 5);
      hit_case("wrap3", 200, 200, 11, 0);
      hit_case("wrap4", 200, 200, 11, 1);
      hit_case("wrap5", 200, 200, 11, 2);

      // Margin boundaries and off-net cells.
      miss_case("miss_185", 185, 200);
      miss_case("miss_180", 180, 200);
      hit_case("hit_186", 186, 200, 11, 3);
      hit_case("hit_234", 234, 200, 11, 4);
      miss_case("miss_235", 235, 200);
      miss_case("miss_30_30", 30, 30);
      miss_case("miss_x500", 500, 200);
      miss_case("miss_y370", 200, 370);
      miss_case("miss_430_70", 430, 70);
      hit_case("hit_left", 70, 130, 5, 2);

      // Bounce: short pulses must not qualify.
      wp0 = wp_cnt;
      selector_x = 10'd200;
      selector_y = 10'd200;
      for (int i = 0; i < 2; i++) begin
         color_switch = 1'b1;
         repeat (2) @(negedge clock);
         color_switch = 1'b0;
         repeat (2) @(negedge clock);
      end
      repeat (6) @(negedge clock);
      check("bounce_no_write", wp_cnt - wp0, 0);
      check("bounce_not_busy", int'(busy), 0);
      color_switch = 1'b1;
      repeat (20) @(negedge clock);
      check("bounce_one_write", wp_cnt - wp0, 1);
      check("hold_busy", int'(busy), 1);
      color_switch = 1'b0;
      repeat (3) @(negedge clock);
      color_switch = 1'b1;
      repeat (20) @(negedge clock);
      check("glitch_no_second", wp_cnt - wp0, 1);
      check("glitch_busy", int'(busy), 1);
      color_switch = 1'b0;
      repeat (20) @(negedge clock);
      check("release_idle", int'(busy), 0);
      rd(11, c);
      check("bounce_color", int'(c), 5);

      // Reset in PRESS_DB with the switch held.
      wp0 = wp_cnt;
      rd_index = 5'd11;
      color_switch = 1'b1;
      repeat (4) @(negedge clock);
      reset = 1'b1;
      repeat (2) @(negedge clock);
      reset = 1'b0;
      check("midrst_no_write", wp_cnt - wp0, 0);
      check("midrst_busy", int'(busy), 0);
      for (int i = 0; i < 40; i++) begin
         if (write_pulse) break;
         @(negedge clock);
      end
      check("midrst_write_seen", int'(write_pulse), 1);
      check("midrst_wr_index", int'(wr_index), 11);
      @(negedge clock);
      check("rw_same_old", int'(rd_color), 2);
      @(negedge clock);
      check("rw_same_new", int'(rd_color), 3);
      color_switch = 1'b0;
      repeat (20) @(negedge clock);
      check("midrst_one_write", wp_cnt - wp0, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
